seg7_scan: RTL and testbench

Hardware scan driver for the 4-digit seven-segment display, directly downstream of the data memory's memory-mapped BCD register (address 0x40000010). It takes the 16-bit BCD register value as four hex digits and time-multiplexes them onto shared active-low segment and anode lines. Each digit slot has a blanking guard against ghosting, leading-zero suppression is optional, and the value is latched once per frame so a CPU store mid-frame never tears the display.

---
 rtl/seg7_scan.sv | 114 +++++++++++
 tb/tb_seg7_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Four-digit seven-segment scan driver with per-slot blanking,
// optional leading-zero suppression and frame-latched display value.
module seg7_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 1000,
   parameter int LZ_BLANK     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bcd_in,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow;

   logic [3:0] digit;
   logic       suppress;
   logic       show;
   logic       frame_start;
   logic [3:0] an_next;
   logic [7:0] seg_next;

   function automatic logic [7:0] decode(input logic [3:0] d);
      logic [7:0] s;
      s = 8'hFF;
      case (d)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         4'hF: s = 8'h8E;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   always_comb begin
      digit    = 4'h0;
      suppress = 1'b0;
      case (idx)
         2'd0: begin
            digit    = shadow[3:0];
            suppress = 1'b0;
         end
         2'd1: begin
            digit    = shadow[7:4];
            suppress = (shadow[15:4] == 12'h000);
         end
         2'd2: begin
            digit    = shadow[11:8];
            suppress = (shadow[15:8] == 8'h00);
         end
         default: begin
            digit    = shadow[15:12];
            suppress = (shadow[15:12] == 4'h0);
         end
      endcase
      if (LZ_BLANK == 0) suppress = 1'b0;
   end

   // Outputs are computed from pre-edge state and registered once.
   always_comb begin
      frame_start = (idx == 2'd0) && (cnt == '0);
      show        = (cnt >= BLANK_END) && !suppress;
      an_next     = 4'hF;
      seg_next    = 8'hFF;
      if (show) begin
         an_next  = ~(4'b0001 << idx);
         seg_next = decode(digit);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         shadow     <= 16'h0000;
         an         <= 4'hF;
         seg        <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (frame_start) shadow <= bcd_in;
         frame_tick <= frame_start;
         an         <= an_next;
         seg        <= seg_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: scan order, leading zeros,
// anti-tearing, full decode sweep and mid-frame reset.
module tb_seg7_scan;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] bcd_in;
   logic [3:0]  an, an_nz;
   logic [7:0]  seg, seg_nz;
   logic        frame_tick, frame_tick_nz;

   int checks   = 0;
   int failures = 0;

   logic [7:0] dec [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   always #5 clk = ~clk;

   seg7_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut (
      .clk(clk), .reset(reset), .bcd_in(bcd_in),
      .an(an), .seg(seg), .frame_tick(frame_tick)
   );

   seg7_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut_nz (
      .clk(clk), .reset(reset), .bcd_in(bcd_in),
      .an(an_nz), .seg(seg_nz), .frame_tick(frame_tick_nz)
   );

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full frame; segs = {d3,d2,d1,d0}, lit = slots shown with LZ on.
   task automatic check_frame(input string tag, input logic [31:0] segs,
                              input logic [3:0] lit, input int chg_at,
                              input logic [15:0] chg_val);
      int slot, c;
      logic on;
      logic [3:0] oh;
      logic [7:0] sv;
      for (int n = 0; n < 32; n++) begin
         step();
         slot = n / 8;
         c    = n % 8;
         on   = (c >= 2);
         oh   = 4'b0001 << slot;
         sv   = segs[slot*8 +: 8];
         check($sformatf("%s e%0d an", tag, n), {4'h0, an},
               (on && lit[slot]) ? {4'h0, ~oh} : 8'h0F);
         check($sformatf("%s e%0d seg", tag, n), seg,
               (on && lit[slot]) ? sv : 8'hFF);
         check($sformatf("%s e%0d ft", tag, n), {7'd0, frame_tick},
               (n == 0) ? 8'd1 : 8'd0);
         check($sformatf("%s e%0d an_nz", tag, n), {4'h0, an_nz},
               on ? {4'h0, ~oh} : 8'h0F);
         check($sformatf("%s e%0d seg_nz", tag, n), seg_nz,
               on ? sv : 8'hFF);
         check($sformatf("%s e%0d ft_nz", tag, n), {7'd0, frame_tick_nz},
               (n == 0) ? 8'd1 : 8'd0);
         if (n == chg_at) bcd_in = chg_val;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      bcd_in = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst%0d an", i), {4'h0, an}, 8'h0F);
         check($sformatf("rst%0d seg", i), seg, 8'hFF);
         check($sformatf("rst%0d ft", i), {7'd0, frame_tick}, 8'd0);
      end
      reset = 1'b0;

      // Value changes at edge 12 must not tear the current frame.
      check_frame("scan1234", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111,
                  12, 16'hFFFF);
      check_frame("ffff", {8'h8E, 8'h8E, 8'h8E, 8'h8E}, 4'b1111,
                  12, 16'h00A0);
      check_frame("00a0", {8'hC0, 8'hC0, 8'h88, 8'hC0}, 4'b0011,
                  12, 16'h0000);
      check_frame("zero", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b0001,
                  12, 16'h0000);

      for (int v = 0; v < 16; v++) begin
         check_frame($sformatf("dec%0h", v),
                     {8'hC0, 8'hC0, 8'hC0, dec[v]}, 4'b0001,
                     12, (v < 15) ? 16'(v + 1) : 16'h1234);
      end

      // Reset lands on edge 20, mid-slot 2.
      for (int n = 0; n < 20; n++) step();
      reset = 1'b1;
      step();
      check("midrst an", {4'h0, an}, 8'h0F);
      check("midrst seg", seg, 8'hFF);
      check("midrst ft", {7'd0, frame_tick}, 8'd0);
      reset  = 1'b0;
      bcd_in = 16'h1234;
      check_frame("restart", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111,
                  -1, 16'h0000);
      step();
      check("frame2 ft", {7'd0, frame_tick}, 8'd1);
      check("frame2 an", {4'h0, an}, 8'h0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
